// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: algorithm codes, Nk/Nr/length lookups,
// round constants and the key-store FSM state encoding.
package aes_key_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned KEY_W  = 256;
   localparam int unsigned BLK_W  = 128;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {
      ALG_128 = 2'b00,
      ALG_192 = 2'b01,
      ALG_256 = 2'b10,
      ALG_BAD = 2'b11
   } alg_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EXPAND = 2'b01,
      ST_READY  = 2'b10
   } state_e;

   // Key length in 32-bit words; the illegal code maps above every legal MAX_NK.
   function automatic logic [3:0] nk_of(input alg_e alg);
      case (alg)
         ALG_128: return 4'd4;
         ALG_192: return 4'd6;
         ALG_256: return 4'd8;
         default: return 4'd15;
      endcase
   endfunction

   // Number of rounds.
   function automatic logic [3:0] nr_of(input alg_e alg);
      case (alg)
         ALG_128: return 4'd10;
         ALG_192: return 4'd12;
         ALG_256: return 4'd14;
         default: return 4'd0;
      endcase
   endfunction

   // Total schedule length in words, 4*(Nr+1).
   function automatic logic [CNT_W-1:0] total_of(input alg_e alg);
      case (alg)
         ALG_128: return 6'd44;
         ALG_192: return 6'd52;
         ALG_256: return 6'd60;
         default: return 6'd0;
      endcase
   endfunction

   // Round constant byte; index 0 corresponds to Rcon[1].
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_key_store_subword.sv
// Combinational AES SubWord: four parallel forward S-box lookups.
module aes_subword (
   input  logic [31:0] word,
   output logic [31:0] sub_c
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // One S-box per byte lane.
   assign sub_c = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_round_key_store.sv
// AES-128/192/256 key expansion (one word per clock) and round-key store with
// encryption- or decryption-order read port.
// Optional feature macro: AES_KEY_ZEROIZE_EN adds a zeroize input that wipes the store.
module aes_round_key_store
   import aes_key_pkg::*;
#(
   parameter int unsigned MAX_NK = 8,
   parameter int unsigned RD_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef AES_KEY_ZEROIZE_EN
   input  logic              zeroize,
`endif
   input  logic [KEY_W-1:0]  key_in,
   input  logic [1:0]        algorithm,
   input  logic              start,
   output logic              busy,
   output logic              keys_valid,
   output logic              cfg_err,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic              rd_inv,
   output logic [BLK_W-1:0]  rd_key,
   output logic              rd_err
);

   localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
   localparam int unsigned AW    = $clog2(DEPTH);

   logic [WORD_W-1:0] w [DEPTH];

   state_e            state_q, state_d;
   alg_e              alg_q, alg_d;
   logic [CNT_W-1:0]  i_q, i_d;
   logic [2:0]        j_q, j_d;
   logic [3:0]        rc_q, rc_d;
   logic              busy_q, busy_d;
   logic              kv_q, kv_d;
   logic              cerr_q, cerr_d;
   logic              load_c, expand_c, zero_c;
   alg_e              alg_in_c;
   logic [3:0]        nk_q_c;

`ifdef AES_KEY_ZEROIZE_EN
   assign zero_c = zeroize;
`else
   assign zero_c = 1'b0;
`endif

   assign alg_in_c = alg_e'(algorithm);
   assign nk_q_c   = nk_of(alg_q);

   // Expansion datapath: next schedule word w[i] from w[i-1] and w[i-Nk].
   logic [WORD_W-1:0] prev_c, old_c, sub_in_c, sub_out_c, temp_c, new_word_c;
   logic [AW-1:0]     prev_addr_c, old_addr_c;

   assign prev_addr_c = AW'(i_q - CNT_W'(1));
   assign old_addr_c  = AW'(i_q - CNT_W'(nk_q_c));
   assign prev_c      = w[prev_addr_c];
   assign old_c       = w[old_addr_c];
   assign sub_in_c    = (j_q == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;

   aes_subword u_subword (
      .word  (sub_in_c),
      .sub_c (sub_out_c)
   );

   // Select the FIPS-197 temp term for the current position within the key group.
   always_comb begin
      temp_c = prev_c;
      if (j_q == 3'd0) begin
         temp_c = sub_out_c ^ {rcon(rc_q), 24'h000000};
      end else if (nk_q_c == 4'd8 && j_q == 3'd4) begin
         temp_c = sub_out_c;
      end
   end

   assign new_word_c = old_c ^ temp_c;

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         alg_q   <= ALG_128;
         i_q     <= '0;
         j_q     <= '0;
         rc_q    <= '0;
         busy_q  <= 1'b0;
         kv_q    <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         alg_q   <= alg_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rc_q    <= rc_d;
         busy_q  <= busy_d;
         kv_q    <= kv_d;
         cerr_q  <= cerr_d;
      end
   end

   // Next-state logic: start acceptance, word sequencing and completion.
   always_comb begin
      state_d  = state_q;
      alg_d    = alg_q;
      i_d      = i_q;
      j_d      = j_q;
      rc_d     = rc_q;
      busy_d   = busy_q;
      kv_d     = kv_q;
      cerr_d   = cerr_q;
      load_c   = 1'b0;
      expand_c = 1'b0;
      if (zero_c) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         kv_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_READY: begin
               if (start) begin
                  if (alg_in_c == ALG_BAD || 32'(nk_of(alg_in_c)) > MAX_NK) begin
                     cerr_d  = 1'b1;
                     kv_d    = 1'b0;
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     load_c  = 1'b1;
                     alg_d   = alg_in_c;
                     i_d     = CNT_W'(nk_of(alg_in_c));
                     j_d     = '0;
                     rc_d    = '0;
                     kv_d    = 1'b0;
                     cerr_d  = 1'b0;
                     busy_d  = 1'b1;
                     state_d = ST_EXPAND;
                  end
               end
            end
            ST_EXPAND: begin
               expand_c = 1'b1;
               i_d      = i_q + CNT_W'(1);
               j_d      = (j_q == 3'(nk_q_c - 4'd1)) ? 3'd0 : j_q + 3'd1;
               if (j_q == 3'd0) begin
                  rc_d = rc_q + 4'd1;
               end
               if (i_q == total_of(alg_q) - CNT_W'(1)) begin
                  busy_d  = 1'b0;
                  kv_d    = 1'b1;
                  state_d = ST_READY;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Word store: wipe, bulk key load at start, or one expanded word per cycle.
   always_ff @(posedge clk) begin
      if (zero_c) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            w[k] <= '0;
         end
      end else if (load_c) begin
         for (int k = 0; k < 8; k++) begin
            w[k] <= key_in[KEY_W-1-32*k -: 32];
         end
      end else if (expand_c) begin
         w[AW'(i_q)] <= new_word_c;
      end
   end

   // Read mapping: encryption or reversed round order, gated by range and validity.
   logic [3:0]       nr_q_c, r_c;
   logic [AW-1:0]    base_c;
   logic             rd_err_c;
   logic [BLK_W-1:0] rd_key_c;

   assign nr_q_c   = nr_of(alg_q);
   assign r_c      = rd_inv ? (nr_q_c - rd_idx) : rd_idx;
   assign base_c   = AW'({r_c, 2'b00});
   assign rd_err_c = !kv_q || (rd_idx > nr_q_c) || zero_c;
   assign rd_key_c = rd_err_c ? '0 :
                     {w[base_c], w[base_c + AW'(1)], w[base_c + AW'(2)], w[base_c + AW'(3)]};

   if (RD_REG != 0) begin : g_rd_reg
      logic [BLK_W-1:0] rd_key_q;
      logic             rd_err_q;

      // Registered read port.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_key_q <= '0;
            rd_err_q <= 1'b0;
         end else begin
            rd_key_q <= rd_key_c;
            rd_err_q <= rd_err_c;
         end
      end

      assign rd_key = rd_key_q;
      assign rd_err = rd_err_q;
   end else begin : g_rd_comb
      assign rd_key = rd_key_c;
      assign rd_err = rd_err_c;
   end

   assign busy       = busy_q;
   assign keys_valid = kv_q;
   assign cfg_err    = cerr_q;

endmodule
